// File: rtl/elevator_request_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : elevator_pkg
// Description : Shared types and constants for the elevator request scheduler.
//               Holds the floor count and floor index width, the scheduler
//               state and direction enums, and a floor one-hot helper.
// Revision    : 1.0 - initial release
// ============================================================================
package elevator_pkg;

  localparam int NUM_FLOORS = 8;
  localparam int FLOOR_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVE_UP   = 2'd1,
    ST_MOVE_DOWN = 2'd2,
    ST_SERVICE   = 2'd3
  } sched_state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_t;

  // One bit set at position f.
  function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] v;
    v    = '0;
    v[f] = 1'b1;
    return v;
  endfunction

endpackage : elevator_pkg
`default_nettype wire

// File: rtl/elevator_request_scheduler_next_floor_finder.sv
`default_nettype none
// ============================================================================
// Module      : elevator_next_floor_finder
// Description : Combinational nearest-pending-floor search. Looks strictly
//               above (DIR_UP) or strictly below (DIR_DOWN) current_floor.
// Ports       : pend          - pending floors, one bit per floor
//               current_floor - search origin (excluded from the search)
//               direction     - DIR_UP / DIR_DOWN; DIR_NONE finds nothing
//               found         - a pending floor exists in that direction
//               floor         - nearest such floor (current_floor if none)
// Revision    : 1.0 - initial release
// ============================================================================
module elevator_next_floor_finder
  import elevator_pkg::*;
(
  input  logic [NUM_FLOORS-1:0] pend,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  dir_t                  direction,
  output logic                  found,
  output logic [FLOOR_W-1:0]    floor
);

  always_comb begin
    found = 1'b0;
    floor = current_floor;
    if (direction == DIR_UP) begin
      // Scan top-down so the last hit is the lowest floor above the car.
      for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
        if (pend[i] && (i > int'(current_floor))) begin
          found = 1'b1;
          floor = i[FLOOR_W-1:0];
        end
      end
    end else if (direction == DIR_DOWN) begin
      // Scan bottom-up so the last hit is the highest floor below the car.
      for (int i = 0; i < NUM_FLOORS; i++) begin
        if (pend[i] && (i < int'(current_floor))) begin
          found = 1'b1;
          floor = i[FLOOR_W-1:0];
        end
      end
    end
  end

endmodule : elevator_next_floor_finder
`default_nettype wire

// File: rtl/elevator_request_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : elevator_request_scheduler
// Description : Latches car and hall requests and schedules car travel with a
//               four-state FSM (IDLE / MOVE_UP / MOVE_DOWN / SERVICE) that
//               keeps its direction while requests remain ahead.
// Ports       : clk, reset (async, active-low)
//               car_req_valid/car_req_floor - car panel request pulse
//               hall_up_req/hall_down_req   - hall button levels
//               current_floor/floor_reached - car position feedback
//               queue_status, hall_up_pending, hall_down_pending - pending sets
//               target_floor, move_up, move_down, door_open - registered drive
// Revision    : 1.0 - initial release
// ============================================================================
module elevator_request_scheduler
  import elevator_pkg::*;
#(
  parameter int DWELL_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  car_req_valid,
  input  logic [FLOOR_W-1:0]    car_req_floor,
  input  logic [NUM_FLOORS-1:0] hall_up_req,
  input  logic [NUM_FLOORS-1:0] hall_down_req,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  floor_reached,
  output logic [NUM_FLOORS-1:0] queue_status,
  output logic [NUM_FLOORS-1:0] hall_up_pending,
  output logic [NUM_FLOORS-1:0] hall_down_pending,
  output logic [FLOOR_W-1:0]    target_floor,
  output logic                  move_up,
  output logic                  move_down,
  output logic                  door_open
);

  // No "up" button on the top floor, no "down" button on the bottom floor.
  localparam logic [NUM_FLOORS-1:0] c_hall_up_mask   = {1'b0, {(NUM_FLOORS-1){1'b1}}};
  localparam logic [NUM_FLOORS-1:0] c_hall_down_mask = {{(NUM_FLOORS-1){1'b1}}, 1'b0};
  localparam logic [7:0]            c_dwell_last     = 8'(DWELL_CYCLES - 1);

  sched_state_t          r_state;
  dir_t                  r_dir;
  logic [7:0]            r_dwell_cnt;
  logic [NUM_FLOORS-1:0] r_queue, r_hall_up, r_hall_down;
  logic [FLOOR_W-1:0]    r_target;
  logic                  r_move_up, r_move_down, r_door_open;

  logic [NUM_FLOORS-1:0] w_cf_onehot, w_pend, w_search_pend, w_absorb_mask;
  logic [NUM_FLOORS-1:0] w_car_raw, w_hu_raw, w_hd_raw;
  logic [NUM_FLOORS-1:0] w_car_set, w_hu_set, w_hd_set;
  logic [NUM_FLOORS-1:0] w_clr_queue, w_clr_hall_up, w_clr_hall_down;
  logic                  w_absorb, w_at_target, w_arrive_up, w_arrive_down;
  logic                  w_idle_service, w_enter_service;
  logic                  w_up_found, w_down_found;
  logic [FLOOR_W-1:0]    w_up_floor, w_down_floor;

  assign w_cf_onehot   = floor_onehot(current_floor);
  assign w_pend        = r_queue | r_hall_up | r_hall_down;
  // The car's own floor is handled explicitly; searches look strictly ahead.
  assign w_search_pend = w_pend & ~w_cf_onehot;

  assign w_car_raw = car_req_valid ? floor_onehot(car_req_floor) : '0;
  assign w_hu_raw  = hall_up_req & c_hall_up_mask;
  assign w_hd_raw  = hall_down_req & c_hall_down_mask;

  // While the door is open, any request for this floor is already satisfied:
  // drop it and hold the door a full dwell longer.
  assign w_absorb_mask = (r_state == ST_SERVICE) ? w_cf_onehot : '0;
  assign w_absorb      = |((w_car_raw | w_hu_raw | w_hd_raw) & w_absorb_mask);
  assign w_car_set     = w_car_raw & ~w_absorb_mask;
  assign w_hu_set      = w_hu_raw & ~w_absorb_mask;
  assign w_hd_set      = w_hd_raw & ~w_absorb_mask;

  assign w_at_target     = floor_reached && (current_floor == r_target);
  assign w_arrive_up     = (r_state == ST_MOVE_UP) && w_at_target;
  assign w_arrive_down   = (r_state == ST_MOVE_DOWN) && w_at_target;
  assign w_idle_service  = (r_state == ST_IDLE) && w_pend[current_floor];
  assign w_enter_service = w_arrive_up || w_arrive_down || w_idle_service;

  // Arrival clears the hall call in the travel direction; the opposite call is
  // only answered too when nothing remains ahead (the car will turn around).
  assign w_clr_queue     = w_enter_service ? w_cf_onehot : '0;
  assign w_clr_hall_up   = (w_arrive_up || w_idle_service || (w_arrive_down && !w_down_found))
                           ? w_cf_onehot : '0;
  assign w_clr_hall_down = (w_arrive_down || w_idle_service || (w_arrive_up && !w_up_found))
                           ? w_cf_onehot : '0;

  elevator_next_floor_finder u_find_up (
    .pend          (w_search_pend),
    .current_floor (current_floor),
    .direction     (DIR_UP),
    .found         (w_up_found),
    .floor         (w_up_floor)
  );

  elevator_next_floor_finder u_find_down (
    .pend          (w_search_pend),
    .current_floor (current_floor),
    .direction     (DIR_DOWN),
    .found         (w_down_found),
    .floor         (w_down_floor)
  );

  // Pending request sets: a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_queue     <= '0;
      r_hall_up   <= '0;
      r_hall_down <= '0;
    end else begin
      r_queue     <= (r_queue & ~w_clr_queue) | w_car_set;
      r_hall_up   <= (r_hall_up & ~w_clr_hall_up) | w_hu_set;
      r_hall_down <= (r_hall_down & ~w_clr_hall_down) | w_hd_set;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_dir       <= DIR_NONE;
      r_dwell_cnt <= '0;
      r_target    <= '0;
      r_move_up   <= 1'b0;
      r_move_down <= 1'b0;
      r_door_open <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_idle_service) begin
            r_state     <= ST_SERVICE;
            r_dir       <= DIR_NONE;
            r_dwell_cnt <= '0;
            r_door_open <= 1'b1;
          end else if (w_up_found) begin
            r_state   <= ST_MOVE_UP;
            r_dir     <= DIR_UP;
            r_target  <= w_up_floor;
            r_move_up <= 1'b1;
          end else if (w_down_found) begin
            r_state     <= ST_MOVE_DOWN;
            r_dir       <= DIR_DOWN;
            r_target    <= w_down_floor;
            r_move_down <= 1'b1;
          end
        end

        ST_MOVE_UP: begin
          if (w_arrive_up) begin
            r_state     <= ST_SERVICE;
            r_dwell_cnt <= '0;
            r_move_up   <= 1'b0;
            r_door_open <= 1'b1;
          end else if (w_pend[current_floor]) begin
            // A call at the floor being passed becomes the nearest stop.
            r_target <= current_floor;
          end else if (w_up_found) begin
            r_target <= w_up_floor;
          end
        end

        ST_MOVE_DOWN: begin
          if (w_arrive_down) begin
            r_state     <= ST_SERVICE;
            r_dwell_cnt <= '0;
            r_move_down <= 1'b0;
            r_door_open <= 1'b1;
          end else if (w_pend[current_floor]) begin
            r_target <= current_floor;
          end else if (w_down_found) begin
            r_target <= w_down_floor;
          end
        end

        ST_SERVICE: begin
          if (w_absorb) begin
            r_dwell_cnt <= '0;
          end else if (r_dwell_cnt == c_dwell_last) begin
            r_dwell_cnt <= '0;
            r_door_open <= 1'b0;
            if ((r_dir == DIR_UP) && w_up_found) begin
              r_state   <= ST_MOVE_UP;
              r_target  <= w_up_floor;
              r_move_up <= 1'b1;
            end else if ((r_dir == DIR_DOWN) && w_down_found) begin
              r_state     <= ST_MOVE_DOWN;
              r_target    <= w_down_floor;
              r_move_down <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_dir   <= DIR_NONE;
            end
          end else begin
            r_dwell_cnt <= r_dwell_cnt + 8'd1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign queue_status      = r_queue;
  assign hall_up_pending   = r_hall_up;
  assign hall_down_pending = r_hall_down;
  assign target_floor      = r_target;
  assign move_up           = r_move_up;
  assign move_down         = r_move_down;
  assign door_open         = r_door_open;

endmodule : elevator_request_scheduler
`default_nettype wire

// File: tb/tb_elevator_request_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_elevator_request_scheduler
// Description : Directed self-checking bench for elevator_request_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_elevator_request_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       car_req_valid = 1'b0;
  logic [2:0] car_req_floor = '0;
  logic [7:0] hall_up_req = '0;
  logic [7:0] hall_down_req = '0;
  logic [2:0] current_floor = '0;
  logic       floor_reached = 1'b0;
  logic [7:0] queue_status, hall_up_pending, hall_down_pending;
  logic [2:0] target_floor;
  logic       move_up, move_down, door_open;

  int n_checks = 0;
  int n_fail   = 0;
  int n_cyc;

  always #5 clk = ~clk;

  elevator_request_scheduler #(.DWELL_CYCLES(16)) u_dut (
    .clk               (clk),
    .reset             (reset),
    .car_req_valid     (car_req_valid),
    .car_req_floor     (car_req_floor),
    .hall_up_req       (hall_up_req),
    .hall_down_req     (hall_down_req),
    .current_floor     (current_floor),
    .floor_reached     (floor_reached),
    .queue_status      (queue_status),
    .hall_up_pending   (hall_up_pending),
    .hall_down_pending (hall_down_pending),
    .target_floor      (target_floor),
    .move_up           (move_up),
    .move_down         (move_down),
    .door_open         (door_open)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; every cycle the drive outputs must be mutually legal.
  task automatic tick();
    @(posedge clk);
    #1;
    check("excl", ((move_up && move_down) || (door_open && (move_up || move_down))) ? 32'd1 : 32'd0,
          32'd0);
  endtask

  task automatic do_reset(input logic [2:0] f);
    reset         = 1'b0;
    car_req_valid = 1'b0;
    hall_up_req   = '0;
    hall_down_req = '0;
    floor_reached = 1'b0;
    current_floor = f;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic pulse_car(input logic [2:0] f);
    car_req_valid = 1'b1;
    car_req_floor = f;
    tick();
    car_req_valid = 1'b0;
  endtask

  task automatic move_to(input logic [2:0] f);
    current_floor = f;
    tick();
  endtask

  task automatic arrive(input logic [2:0] f);
    current_floor = f;
    floor_reached = 1'b1;
    tick();
    floor_reached = 1'b0;
  endtask

  // Edges until the door closes, bounded so a stuck door cannot hang the run.
  task automatic wait_close(output int cycles);
    cycles = 0;
    while (door_open && cycles < 64) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state, then car request to floor 5 -------------
    reset = 1'b0;
    repeat (2) tick();
    check("rst_queue", queue_status, 8'h00);
    check("rst_hall", {hall_up_pending, hall_down_pending}, 16'h0000);
    check("rst_drive", {target_floor, move_up, move_down, door_open}, 6'b000_000);
    reset = 1'b1;
    tick();
    check("idle_drive", {move_up, move_down, door_open}, 3'b000);

    pulse_car(3'd5);
    check("s1_queue", queue_status, 8'h20);
    check("s1_move_lat", move_up, 1'b0);
    tick();
    check("s1_move_up", move_up, 1'b1);
    check("s1_target", target_floor, 3'd5);
    move_to(3'd1);
    arrive(3'd2);
    check("s1_ignore_reach", {move_up, door_open}, 2'b10);
    move_to(3'd3);
    move_to(3'd4);
    arrive(3'd5);
    check("s1_door", {move_up, door_open}, 2'b01);
    check("s1_queue_clr", queue_status, 8'h00);
    wait_close(n_cyc);
    check("s1_dwell", n_cyc, 16);
    tick();
    check("s1_idle", {move_up, move_down, door_open}, 3'b000);

    // ---------------- intermediate stop picked up while moving up ----------
    do_reset(3'd1);
    pulse_car(3'd6);
    tick();
    check("s2_target6", {move_up, target_floor}, {1'b1, 3'd6});
    move_to(3'd2);
    pulse_car(3'd3);
    tick();
    check("s2_target3", target_floor, 3'd3);
    arrive(3'd3);
    check("s2_door3", door_open, 1'b1);
    check("s2_queue3", queue_status, 8'h40);
    wait_close(n_cyc);
    check("s2_dwell3", n_cyc, 16);
    check("s2_resume", {move_up, target_floor}, {1'b1, 3'd6});
    arrive(3'd4);
    check("s2_pass4", {move_up, door_open}, 2'b10);
    move_to(3'd5);
    arrive(3'd6);
    check("s2_door6", {door_open, queue_status}, {1'b1, 8'h00});

    // ---------------- direction retention: 6 before 2 -----------------------
    do_reset(3'd4);
    pulse_car(3'd6);
    tick();
    check("s3_up", {move_up, target_floor}, {1'b1, 3'd6});
    hall_up_req = 8'h04;
    tick();
    hall_up_req = 8'h00;
    check("s3_hall_up2", hall_up_pending, 8'h04);
    tick();
    check("s3_keep6", {move_up, move_down, target_floor}, {2'b10, 3'd6});
    move_to(3'd5);
    arrive(3'd6);
    check("s3_door6", {door_open, queue_status, move_down}, {1'b1, 8'h00, 1'b0});
    wait_close(n_cyc);
    check("s3_dwell6", n_cyc, 16);
    n_cyc = 0;
    while (!move_down && n_cyc < 4) begin
      tick();
      n_cyc++;
    end
    check("s3_down", {move_down, target_floor}, {1'b1, 3'd2});
    move_to(3'd5);
    move_to(3'd4);
    move_to(3'd3);
    arrive(3'd2);
    check("s3_door2", {door_open, move_down}, 2'b10);
    check("s3_hall_clr", hall_up_pending, 8'h00);

    // ---------------- request absorbed during dwell ------------------------
    do_reset(3'd3);
    pulse_car(3'd3);
    check("s4_queue", queue_status, 8'h08);
    tick();
    check("s4_door", {door_open, queue_status}, {1'b1, 8'h00});
    repeat (5) tick();
    hall_up_req = 8'h08;
    tick();
    hall_up_req = 8'h00;
    check("s4_absorb", hall_up_pending, 8'h00);
    wait_close(n_cyc);
    check("s4_dwell", n_cyc, 16);
    check("s4_after", {hall_up_pending, move_up, move_down}, {8'h00, 2'b00});

    // ---------------- nonexistent hall buttons ignored ---------------------
    do_reset(3'd3);
    hall_down_req = 8'h01;
    hall_up_req   = 8'h80;
    repeat (3) tick();
    check("s5_pending", {hall_up_pending, hall_down_pending}, 16'h0000);
    check("s5_idle", {move_up, move_down, door_open}, 3'b000);
    hall_down_req = 8'h00;
    hall_up_req   = 8'h00;

    // ---------------- async reset mid MOVE_DOWN -----------------------------
    do_reset(3'd4);
    pulse_car(3'd0);
    tick();
    check("s6_down", {move_down, target_floor}, {1'b1, 3'd0});
    pulse_car(3'd7);
    check("s6_queue", queue_status, 8'h81);
    #3;
    reset = 1'b0;
    #1;
    check("s6_async_pend", {queue_status, hall_up_pending, hall_down_pending}, 24'h0);
    check("s6_async_drive", {target_floor, move_up, move_down, door_open}, 6'b000_000);
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
    check("s6_post_idle", {queue_status, move_up, move_down, door_open}, {8'h00, 3'b000});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_elevator_request_scheduler
`default_nettype wire

// File: doc/elevator_request_scheduler.md
ELEVATOR_REQUEST_SCHEDULER -- requirements
Module: elevator_request_scheduler

Interface
REQ-001 Parameter DWELL_CYCLES, default 16: door-open dwell length in clk cycles, legal range 1..255.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset; all state is cleared while reset=0.
REQ-004 car_req_valid  input  1  one-cycle pulse; car panel floor request is valid this cycle.
REQ-005 car_req_floor  input  3  requested floor (0..7), qualified by car_req_valid.
REQ-006 hall_up_req  input  8  per-floor hall "up" button level; bit 7 is ignored.
REQ-007 hall_down_req  input  8  per-floor hall "down" button level; bit 0 is ignored.
REQ-008 current_floor  input  3  floor the car is at or passing.
REQ-009 floor_reached  input  1  one-cycle pulse; car is aligned at current_floor.
REQ-010 queue_status  output  8  pending car requests, one bit per floor; drives the car panel lights.
REQ-011 hall_up_pending  output  8  pending hall-up requests.
REQ-012 hall_down_pending  output  8  pending hall-down requests.
REQ-013 target_floor  output  3  floor currently being travelled to.
REQ-014 move_up  output  1  level; motor drive up.
REQ-015 move_down  output  1  level; motor drive down.
REQ-016 door_open  output  1  level; high throughout SERVICE.

Function
REQ-017 Request latch: car_req_valid sets queue_status[car_req_floor]; a high hall_up_req[f] or hall_down_req[f] sets the matching pending bit, with a 1-cycle latency to the outputs.
REQ-018 Pending set pend[f] = queue_status[f] | hall_up_pending[f] | hall_down_pending[f].
REQ-019 FSM states: IDLE, MOVE_UP, MOVE_DOWN, SERVICE; all outputs are registered.
REQ-020 IDLE transitions, in priority order:
- pend[current_floor] -> SERVICE;
- any pend above current_floor -> MOVE_UP, target = nearest pending floor above;
- any pend below -> MOVE_DOWN, target = nearest pending floor below;
- otherwise stay in IDLE.
REQ-021 MOVE_UP: move_up=1 and target_floor is re-evaluated every cycle to the nearest pending floor above current_floor, so a new request between the car and the target is picked up.
REQ-022 MOVE_DOWN mirrors REQ-021 using floors below current_floor.
REQ-023 MOVE_x to SERVICE: occurs when floor_reached=1 and current_floor==target_floor; floor_reached at any other floor is ignored.
REQ-024 On SERVICE entry:
- clear queue_status[current_floor];
- clear the hall bit at current_floor in the arrival direction;
- when no pend remains ahead, also clear the opposite hall bit.
REQ-025 SERVICE: door_open=1, move_up=move_down=0, and the dwell counter counts DWELL_CYCLES cycles, then the FSM goes to IDLE (door_open deasserts on the same edge).
REQ-026 A request for current_floor arriving in SERVICE is absorbed: its bit is never set and the dwell counter restarts.
REQ-027 Direction retention: SERVICE exit goes back to the prior direction when pend remains ahead in that direction; otherwise behaviour follows REQ-020.
REQ-028 Simultaneous set and clear of the same bit outside REQ-026: set wins.
REQ-029 move_up and move_down are never high together, and neither is high while door_open=1.

Reset
REQ-030 Reset values: FSM=IDLE, all pending vectors=0, target_floor=0, move_up=move_down=door_open=0, dwell counter=0, retained direction=none.
REQ-031 Reset asserted mid-motion or mid-dwell drops all outputs immediately (asynchronously) and discards every request.

Structure
REQ-032 elevator_pkg holds:
- NUM_FLOORS=8;
- FLOOR_W=3;
- the scheduler state enum;
- the direction enum {DIR_NONE, DIR_UP, DIR_DOWN}.
REQ-033 The nearest-floor search is a combinational sub-module, elevator_next_floor_finder.
- Inputs: pend, current_floor, direction.
- Outputs: found, floor.

Verification
REQ-034 Reset, idle; car_req 5 at floor 0 -> queue_status=0x20, move_up next cycle, target 5; floor_reached@5 -> door_open for 16 cycles, queue_status=0x00.
REQ-035 Moving up to 6 from floor 1; car_req 3 -> target becomes 3, the car stops at 3, then resumes to 6.
REQ-036 At floor 4 in MOVE_UP with pending {6, 2} -> serves 6 first, then 2; move_down is never asserted before 6 is serviced.
REQ-037 In SERVICE at 3; hall_up_req[3] pulsed mid-dwell -> hall_up_pending[3] stays 0 and dwell lasts 16 cycles from the pulse.
REQ-038 hall_down_req[0] and hall_up_req[7] asserted -> no pending bits set, FSM stays IDLE.
REQ-039 Reset pulled low mid-MOVE_DOWN with pending 0x81 -> all outputs 0 within the same cycle; after release, IDLE with no pending requests.
